// File: rtl/game_pkg.sv
// Shared types and defaults for the game-flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [2:0] LIVES_FULL = 3'b111;
  localparam logic [2:0] LIVES_NONE = 3'b000;

  localparam int unsigned INVULN_FRAMES_DEF = 60;
  localparam int unsigned OVER_FRAMES_DEF   = 180;
  localparam int unsigned SCORE_MAX_DEF     = 999;

  function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// 8-bit frame down-counter shared by the INVULN and OVER windows; saturates at zero.
module frame_timer (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       zero,
  output logic [7:0] count
);

  logic [7:0] r_cnt;

  // load has priority over a coincident tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= 8'd0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign zero  = (r_cnt == 8'd0);
  assign count = r_cnt;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM owning lives, score and flags. Define GAME_FLOW_HISCORE_EN to add the
// hiscore register and port.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int unsigned OVER_FRAMES   = OVER_FRAMES_DEF,
  parameter int unsigned SCORE_MAX     = SCORE_MAX_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic       hit,
  input  logic       score_inc,
  output state_t     game_state,
  output logic [2:0] lives,
  output logic [9:0] score,
  output logic       play_en,
  output logic       invuln,
  output logic       game_over
`ifdef GAME_FLOW_HISCORE_EN
  ,
  output logic [9:0] hiscore
`endif
);

  localparam logic [7:0] InvulnVal = 8'(INVULN_FRAMES);
  localparam logic [7:0] OverVal   = 8'(OVER_FRAMES);
  localparam logic [9:0] ScoreMax  = 10'(SCORE_MAX);

  state_t     r_state;
  logic [2:0] r_lives;
  logic [9:0] r_score;
  logic       r_start_q;
  logic       r_play_en;
  logic       r_invuln;
  logic       r_game_over;

  logic       w_start_rise;
  logic       w_last_life;
  logic [9:0] w_score_plus;
  logic [9:0] w_score_final;
  logic       w_timer_load;
  logic [7:0] w_timer_val;
  logic       w_timer_zero;
  logic [7:0] w_timer_cnt;

  assign w_start_rise  = start_key & ~r_start_q;
  assign w_last_life   = (r_lives == 3'b001);
  assign w_score_plus  = (r_score >= ScoreMax) ? r_score : r_score + 10'd1;
  assign w_score_final = score_inc ? w_score_plus : r_score;
  assign w_timer_load  = (r_state == S_PLAY) && hit;
  assign w_timer_val   = w_last_life ? OverVal : InvulnVal;

  frame_timer u_frame_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (w_timer_load),
    .load_val (w_timer_val),
    .tick     (frame_tick),
    .zero     (w_timer_zero),
    .count    (w_timer_cnt)
  );

`ifdef GAME_FLOW_HISCORE_EN
  logic [9:0] r_hiscore;
  assign hiscore = r_hiscore;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_START;
      r_lives     <= LIVES_FULL;
      r_score     <= 10'd0;
      r_start_q   <= 1'b1;
      r_play_en   <= 1'b0;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
`ifdef GAME_FLOW_HISCORE_EN
      r_hiscore   <= 10'd0;
`endif
    end else begin
      r_start_q <= start_key;
      unique case (r_state)
        S_START: begin
          if (w_start_rise) begin
            r_state   <= S_PLAY;
            r_play_en <= 1'b1;
          end
        end
        S_PLAY: begin
          r_score <= w_score_final;
          if (hit && w_last_life) begin
            // a coincident score_inc is banked before the score freezes
            r_lives     <= LIVES_NONE;
            r_state     <= S_OVER;
            r_play_en   <= 1'b0;
            r_game_over <= 1'b1;
`ifdef GAME_FLOW_HISCORE_EN
            r_hiscore   <= max10(r_hiscore, w_score_final);
`endif
          end else if (hit) begin
            r_lives  <= r_lives >> 1;
            r_state  <= S_INVULN;
            r_invuln <= 1'b1;
          end
        end
        S_INVULN: begin
          r_score <= w_score_final;
          if (frame_tick && (w_timer_cnt == 8'd1)) begin
            r_state  <= S_PLAY;
            r_invuln <= 1'b0;
          end
        end
        S_OVER: begin
          if (w_start_rise && w_timer_zero) begin
            r_state     <= S_PLAY;
            r_lives     <= LIVES_FULL;
            r_score     <= 10'd0;
            r_play_en   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

  assign game_state = r_state;
  assign lives      = r_lives;
  assign score      = r_score;
  assign play_en    = r_play_en;
  assign invuln     = r_invuln;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl (INVULN_FRAMES=4, OVER_FRAMES=3, SCORE_MAX=999).
module tb_game_flow_ctrl;

  localparam int InvF  = 4;
  localparam int OverF = 3;
  localparam int SMax  = 999;

  localparam int SelState = 0, SelLives = 1, SelScore = 2, SelPlay = 3, SelInv = 4,
                 SelOver = 5, SelHi = 6;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick, start_key, hit, score_inc;
  game_pkg::state_t game_state;
  logic [2:0] lives;
  logic [9:0] score;
  logic       play_en, invuln, game_over;
`ifdef GAME_FLOW_HISCORE_EN
  logic [9:0] hiscore;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;
  exp_t sb_q[$];

  game_flow_ctrl #(
    .INVULN_FRAMES (InvF),
    .OVER_FRAMES   (OverF),
    .SCORE_MAX     (SMax)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .start_key  (start_key),
    .hit        (hit),
    .score_inc  (score_inc),
    .game_state (game_state),
    .lives      (lives),
    .score      (score),
    .play_en    (play_en),
    .invuln     (invuln),
    .game_over  (game_over)
`ifdef GAME_FLOW_HISCORE_EN
    ,
    .hiscore    (hiscore)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      SelState: return int'(game_state);
      SelLives: return int'(lives);
      SelScore: return int'(score);
      SelPlay:  return int'(play_en);
      SelInv:   return int'(invuln);
      SelOver:  return int'(game_over);
`ifdef GAME_FLOW_HISCORE_EN
      SelHi:    return int'(hiscore);
`endif
      default:  return -1;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_hi(input string tag, input int exp);
`ifdef GAME_FLOW_HISCORE_EN
    push(tag, SelHi, exp);
`else
    if (exp < 0) $display("unused hiscore expectation %s", tag);
`endif
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
    drain();
    hit        = 1'b0;
    score_inc  = 1'b0;
    frame_tick = 1'b0;
  endtask

  // Non-fatal hit followed by exactly InvF frame ticks back to PLAY.
  task automatic hit_nonfatal(input int exp_lives);
    hit = 1'b1;
    push("nf_lives", SelLives, exp_lives);
    push("nf_state", SelState, 2);
    push("nf_invuln", SelInv, 1);
    cycle();
    for (int i = 1; i <= InvF; i++) begin
      frame_tick = 1'b1;
      push("inv_tick_state", SelState, (i == InvF) ? 1 : 2);
      cycle();
    end
    push("inv_exit_invuln", SelInv, 0);
    cycle();
  endtask

  task automatic fatal_hit(input int exp_score, input int exp_hi);
    hit = 1'b1;
    push("fatal_state", SelState, 3);
    push("fatal_lives", SelLives, 0);
    push("fatal_over", SelOver, 1);
    push("fatal_play_en", SelPlay, 0);
    push("fatal_score", SelScore, exp_score);
    push_hi("fatal_hiscore", exp_hi);
    cycle();
  endtask

  // OVER hold: a press before the timer expires is discarded, the next one restarts.
  task automatic restart_from_over();
    for (int i = 0; i < OverF - 1; i++) begin
      frame_tick = 1'b1;
      push("over_hold", SelState, 3);
      cycle();
    end
    start_key = 1'b0;
    cycle();
    start_key = 1'b1;
    push("over_early_start", SelState, 3);
    cycle();
    start_key = 1'b0;
    frame_tick = 1'b1;
    push("over_last_tick", SelState, 3);
    cycle();
    start_key = 1'b1;
    push("restart_state", SelState, 1);
    push("restart_lives", SelLives, 7);
    push("restart_score", SelScore, 0);
    push("restart_over", SelOver, 0);
    push("restart_play_en", SelPlay, 1);
    cycle();
  endtask

  initial begin
    Reset_n = 1'b0;
    start_key = 1'b1;
    hit = 1'b0;
    score_inc = 1'b0;
    frame_tick = 1'b0;
    #1;
    push("rst_state", SelState, 0);
    push("rst_lives", SelLives, 7);
    push("rst_score", SelScore, 0);
    push("rst_play_en", SelPlay, 0);
    push("rst_invuln", SelInv, 0);
    push("rst_over", SelOver, 0);
    push_hi("rst_hiscore", 0);
    cycle();
    cycle();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("held_key_no_start", SelState, 0);
      cycle();
    end
    start_key = 1'b0;
    push("release_no_start", SelState, 0);
    cycle();
    start_key = 1'b1;
    push("press_state", SelState, 1);
    push("press_play_en", SelPlay, 1);
    cycle();

    // Game 1: hit with coincident tick (load wins), hit ignored in INVULN
    hit = 1'b1;
    frame_tick = 1'b1;
    push("hit1_lives", SelLives, 3);
    push("hit1_state", SelState, 2);
    push("hit1_invuln", SelInv, 1);
    push("hit1_play_en", SelPlay, 1);
    cycle();
    hit = 1'b1;
    score_inc = 1'b1;
    push("inv_hit_lives", SelLives, 3);
    push("inv_hit_state", SelState, 2);
    push("inv_score", SelScore, 1);
    cycle();
    for (int i = 1; i <= InvF; i++) begin
      frame_tick = 1'b1;
      push("hit1_tick_state", SelState, (i == InvF) ? 1 : 2);
      cycle();
    end
    hit_nonfatal(1);
    for (int i = 2; i <= 10; i++) begin
      score_inc = 1'b1;
      push("play_score", SelScore, i);
      cycle();
    end
    score_inc = 1'b1;
    fatal_hit(11, 11);
    hit = 1'b1;
    score_inc = 1'b1;
    push("over_score_frozen", SelScore, 11);
    push("over_lives", SelLives, 0);
    cycle();
    restart_from_over();

    // Game 2: saturation
    for (int i = 1; i <= 1005; i++) begin
      score_inc = 1'b1;
      push("sat_score", SelScore, (i < SMax) ? i : SMax);
      cycle();
    end
    hit_nonfatal(3);
    hit_nonfatal(1);
    fatal_hit(SMax, SMax);
    restart_from_over();

    // Game 3: lower score keeps the best
    for (int i = 1; i <= 30; i++) begin
      score_inc = 1'b1;
      push("g3_score", SelScore, i);
      cycle();
    end
    hit_nonfatal(3);
    hit_nonfatal(1);
    fatal_hit(30, SMax);
    restart_from_over();

    // Asynchronous reset mid-game
    for (int i = 1; i <= 5; i++) begin
      score_inc = 1'b1;
      push("g4_score", SelScore, i);
      cycle();
    end
    #3;
    Reset_n = 1'b0;
    #1;
    push("mid_rst_state", SelState, 0);
    push("mid_rst_score", SelScore, 0);
    push("mid_rst_lives", SelLives, 7);
    push("mid_rst_play_en", SelPlay, 0);
    push_hi("mid_rst_hiscore", 0);
    drain();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
